// File: rtl/conv1_acc_relu_if.sv
// Stream bundle between the conv1 multiplier, this accumulator and the pooling stage.
// The master side is the producer/consumer pair around the block; the slave side is the block.
interface conv1_acc_relu_if #(
  parameter int PROD_WIDTH = 20,
  parameter int BIAS_WIDTH = 20,
  parameter int OUT_WIDTH  = 14
);
  logic signed [PROD_WIDTH-1:0] in_data;
  logic                         in_valid;
  logic                         in_last;
  logic                         in_ready;
  logic signed [BIAS_WIDTH-1:0] bias;
  logic signed [OUT_WIDTH-1:0]  out_data;
  logic                         out_valid;
  logic                         out_ready;
  logic                         err_len;

  modport master (
    output in_data, in_valid, in_last, bias, out_ready,
    input  in_ready, out_data, out_valid, err_len
  );

  modport slave (
    input  in_data, in_valid, in_last, bias, out_ready,
    output in_ready, out_data, out_valid, err_len
  );
endinterface

// File: rtl/conv1_acc_relu.sv
// conv1 window accumulator: sums one kernel window of products, adds bias,
// applies ReLU, rescales by an arithmetic right shift and saturates.
//
// state | meaning
// ------+----------------------------------------------------------
// ACC   | accepting products, accumulating the current window
// FIN   | one cycle: bias add, ReLU, shift, saturate into out_data
// OUT   | result presented, waiting for out_ready
module conv1_acc_relu #(
  parameter int PROD_WIDTH  = 20,
  parameter int KERNEL_SIZE = 25,
  parameter int ACC_WIDTH   = 26,
  parameter int BIAS_WIDTH  = 20,
  parameter int SHIFT       = 5,
  parameter int OUT_WIDTH   = 14
) (
  input logic ap_clk,
  input logic ap_rst_n,
  conv1_acc_relu_if.slave bus
);
  localparam int CNT_WIDTH = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(KERNEL_SIZE - 1);
  localparam logic signed [ACC_WIDTH-1:0] OUT_MAX = ACC_WIDTH'((2 ** (OUT_WIDTH - 1)) - 1);

  typedef enum logic [1:0] {ST_ACC, ST_FIN, ST_OUT} state_t;

  state_t state, state_nxt;

  logic [CNT_WIDTH-1:0]         count;
  logic signed [ACC_WIDTH-1:0]  acc;
  logic signed [BIAS_WIDTH-1:0] bias_q;
  logic signed [OUT_WIDTH-1:0]  out_data_q;
  logic                         out_valid_q;
  logic                         err_len_q;

  logic                         in_ready_c;
  logic                         accept;
  logic                         win_end;
  logic signed [ACC_WIDTH-1:0]  prod_ext;
  logic signed [ACC_WIDTH-1:0]  sum_s;
  logic signed [ACC_WIDTH-1:0]  shifted;
  logic signed [OUT_WIDTH-1:0]  act;

  assign accept   = bus.in_valid & in_ready_c;
  // A window closes on the KERNEL_SIZE-th beat or early on in_last, whichever comes first.
  assign win_end  = (count == LAST_CNT) | bus.in_last;
  assign prod_ext = {{(ACC_WIDTH-PROD_WIDTH){bus.in_data[PROD_WIDTH-1]}}, bus.in_data};

  // State register.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) state <= ST_ACC;
    else           state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_ACC:  if (accept && win_end) state_nxt = ST_FIN;
      ST_FIN:  state_nxt = ST_OUT;
      ST_OUT:  if (bus.out_ready) state_nxt = ST_ACC;
      default: state_nxt = ST_ACC;
    endcase
  end

  // Output decode: inputs are only taken while accumulating.
  always_comb begin
    in_ready_c = 1'b0;
    if (state == ST_ACC) in_ready_c = 1'b1;
  end

  // Bias add, ReLU, rescale and saturate; a non-positive sum is clamped to zero before shifting.
  always_comb begin
    sum_s   = acc + {{(ACC_WIDTH-BIAS_WIDTH){bias_q[BIAS_WIDTH-1]}}, bias_q};
    shifted = sum_s >>> SHIFT;
    act     = '0;
    if (sum_s <= 0)            act = '0;
    else if (shifted > OUT_MAX) act = OUT_MAX[OUT_WIDTH-1:0];
    else                       act = shifted[OUT_WIDTH-1:0];
  end

  // Accumulator, bias capture, result register and sticky length error.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      count       <= '0;
      acc         <= '0;
      bias_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      err_len_q   <= 1'b0;
    end else begin
      case (state)
        ST_ACC: begin
          if (accept) begin
            if (count == '0) begin
              acc    <= prod_ext;
              bias_q <= bus.bias;
            end else begin
              acc <= acc + prod_ext;
            end
            if ((bus.in_last && (count != LAST_CNT)) || (!bus.in_last && (count == LAST_CNT)))
              err_len_q <= 1'b1;
            count <= win_end ? '0 : count + 1'b1;
          end
        end
        ST_FIN: begin
          out_data_q  <= act;
          out_valid_q <= 1'b1;
        end
        ST_OUT: begin
          if (bus.out_ready) out_valid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.err_len   = err_len_q;
endmodule

// File: tb/tb_conv1_acc_relu.sv
// Directed bench for conv1_acc_relu with hand-computed window results.
module tb_conv1_acc_relu;
  logic ap_clk;
  logic ap_rst_n;
  int   checks;
  int   errors;

  conv1_acc_relu_if bus ();

  conv1_acc_relu dut (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .bus      (bus.slave)
  );

  // Free-running 100 MHz clock.
  initial begin
    ap_clk = 1'b0;
    forever #5 ap_clk = ~ap_clk;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  // Drives one window; last_idx < 0 means no in_last, bias b on first beat then b_mid.
  // hold > 0 keeps out_ready low for that many cycles with a blocked beat offered.
  task automatic run_window(input string tag, input int val, input int last_idx,
                            input int b, input int b_mid, input int exp_out,
                            input int exp_err, input int hold);
    int n;
    n = (last_idx >= 0) ? last_idx + 1 : 25;
    bus.out_ready = (hold > 0) ? 1'b0 : 1'b1;
    for (int i = 0; i < n; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 20'(val);
      bus.in_last  = (i == last_idx);
      bus.bias     = (i == 0) ? 20'(b) : 20'(b_mid);
      tick();
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.bias     = 20'(b_mid);
    chk({tag, "_fin_valid"}, int'(bus.out_valid), 0);
    chk({tag, "_fin_ready"}, int'(bus.in_ready), 0);
    tick();
    chk({tag, "_valid"}, int'(bus.out_valid), 1);
    chk({tag, "_data"}, int'(bus.out_data), exp_out);
    chk({tag, "_err"}, int'(bus.err_len), exp_err);
    for (int h = 0; h < hold; h++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 20'sd1000;
      tick();
      chk({tag, "_hold_valid"}, int'(bus.out_valid), 1);
      chk({tag, "_hold_data"}, int'(bus.out_data), exp_out);
      chk({tag, "_hold_ready"}, int'(bus.in_ready), 0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    chk({tag, "_done_valid"}, int'(bus.out_valid), 0);
    chk({tag, "_done_ready"}, int'(bus.in_ready), 1);
  endtask

  task automatic do_reset();
    ap_rst_n = 1'b0;
    #13;
    ap_rst_n = 1'b1;
    tick();
  endtask

  // Directed sequence.
  initial begin
    checks        = 0;
    errors        = 0;
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.bias      = '0;
    bus.out_ready = 1'b1;
    ap_rst_n      = 1'b0;
    #23;
    ap_rst_n = 1'b1;
    tick();
    chk("rst_ready", int'(bus.in_ready), 1);
    chk("rst_valid", int'(bus.out_valid), 0);
    chk("rst_data", int'(bus.out_data), 0);
    chk("rst_err", int'(bus.err_len), 0);

    // 25*64 = 1600, >>5 = 50
    run_window("w64", 64, 24, 0, 0, 50, 0, 0);
    // 25*32 + 200 = 1000, >>5 = 31; mid-window bias ignored
    run_window("w32b", 32, 24, 200, 9999, 31, 0, 0);
    // negative sum -> ReLU zero
    run_window("wneg", -100, 24, 0, 0, 0, 0, 0);
    // 25*524287 = 13107175, >>5 = 409599 -> saturate 8191
    run_window("wsat", 524287, 24, 0, 0, 8191, 0, 0);
    // backpressure for 10 cycles, then a normal window
    run_window("wbp", 64, 24, 0, 0, 50, 0, 10);
    run_window("wbp2", 64, 24, 0, 0, 50, 0, 0);
    // early in_last on 10th beat: 640 >> 5 = 20, sticky error
    run_window("wshort", 64, 9, 0, 0, 20, 1, 0);
    run_window("wafter", 64, 24, 0, 0, 50, 1, 0);

    // missing in_last on 25th beat: result correct, error set
    do_reset();
    chk("rst2_err", int'(bus.err_len), 0);
    run_window("wnolast", 64, -1, 0, 0, 50, 1, 0);

    // async reset after 12 beats discards the partial window
    for (int i = 0; i < 12; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 20'sd64;
      bus.in_last  = 1'b0;
      bus.bias     = 20'sd500;
      tick();
    end
    bus.in_valid = 1'b0;
    #2;
    ap_rst_n = 1'b0;
    #1;
    chk("arst_valid", int'(bus.out_valid), 0);
    chk("arst_data", int'(bus.out_data), 0);
    chk("arst_err", int'(bus.err_len), 0);
    #4;
    ap_rst_n = 1'b1;
    tick();
    run_window("wpost", 64, 24, 0, 0, 50, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
